sha_msg_padder: RTL and testbench

- Front-end feeder for the SHA-2 hashing unit.
- Accepts a message as a stream of 32-bit big-endian words with a valid/ready handshake.
- Applies FIPS 180-4 padding: 0x80 marker, zero fill, and a length field of 64 bits (SHA-256) or 128 bits (SHA-384/512).
- Presents each assembled 512/1024-bit block to the hash core with start/valid strobes, then waits for the core's per-block completion before issuing the next block.

---
 rtl/sha_msg_padder.sv | 236 +++++++++++++++++++++++
 tb/tb_sha_msg_padder.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_padder.sv
// sha_msg_padder: FIPS 180-4 message padding front end.
// Packs 32-bit words into 512/1024-bit blocks for the SHA-2 core.
module sha_msg_padder #(
  parameter int CNT_W = 61
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic [1:0]    cfg_hash_size,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  input  logic [2:0]    in_bytes,
  output logic [1023:0] blk,
  output logic          blk_start,
  output logic          blk_valid,
  input  logic          blk_done,
  output logic [1:0]    hash_size,
  output logic          msg_done,
  output logic          cfg_err
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    SEND,
    WAIT
  } state_t;

  state_t              state_q, state_n;
  logic [5:0]          idx_q, idx_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [1:0]          size_q, size_n;
  logic                mark_q, mark_n;
  logic                fin_q, fin_n;
  logic                pend_q, pend_n;
  logic                first_q, first_n;
  logic                done_q, done_n;
  logic                err_q, err_n;
  logic [1023:0]       blk_q;

  logic                wr_en;
  logic [31:0]         wr_word;
  logic                wr_len;
  logic                clr_blk;

  logic                wide;
  logic [5:0]          n_words;
  logic [5:0]          last_idx;
  logic [5:0]          len_idx;
  logic [5:0]          slot;
  logic [2:0]          nb;
  logic [127:0]        len_field;

  assign wide     = size_q[1];
  assign n_words  = wide ? 6'd32 : 6'd16;
  assign last_idx = n_words - 6'd1;
  assign len_idx  = wide ? 6'd28 : 6'd14;
  // narrow word i lives where wide word i+16 would
  assign slot     = wide ? idx_q : idx_q + 6'd16;
  assign nb       = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign len_field = 128'({cnt_q, 3'b000});

  function automatic logic [31:0] pad_last(
    input logic [31:0] d,
    input logic [2:0]  n
  );
    case (n)
      3'd0:    pad_last = 32'h8000_0000;
      3'd1:    pad_last = {d[31:24], 24'h80_0000};
      3'd2:    pad_last = {d[31:16], 16'h8000};
      default: pad_last = {d[31:8], 8'h80};
    endcase
  endfunction

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    size_n  = size_q;
    mark_n  = mark_q;
    fin_n   = fin_q;
    pend_n  = pend_q;
    first_n = first_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    wr_en   = 1'b0;
    wr_word = 32'h0;
    wr_len  = 1'b0;
    clr_blk = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_hash_size == 2'b00) begin
            err_n = 1'b1;
          end else begin
            size_n  = cfg_hash_size;
            clr_blk = 1'b1;
            idx_n   = 6'd0;
            cnt_n   = '0;
            mark_n  = 1'b0;
            fin_n   = 1'b0;
            pend_n  = 1'b0;
            first_n = 1'b1;
            state_n = FILL;
          end
        end
      end
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          idx_n = idx_q + 6'd1;
          if (in_last) begin
            cnt_n = cnt_q + CNT_W'(nb);
            if (nb != 3'd4) begin
              wr_word = pad_last(in_data, nb);
              mark_n  = 1'b1;
              state_n = PAD;
            end else begin
              wr_word = in_data;
              mark_n  = 1'b0;
              if (idx_q == last_idx) begin
                fin_n   = 1'b0;
                pend_n  = 1'b1;
                state_n = SEND;
              end else begin
                state_n = PAD;
              end
            end
          end else begin
            cnt_n   = cnt_q + CNT_W'(4);
            wr_word = in_data;
            if (idx_q == last_idx) begin
              fin_n   = 1'b0;
              pend_n  = 1'b0;
              state_n = SEND;
            end
          end
        end
      end
      PAD: begin
        if (idx_q == n_words) begin
          fin_n   = 1'b0;
          pend_n  = 1'b1;
          state_n = SEND;
        end else if (mark_q && idx_q == len_idx) begin
          wr_len  = 1'b1;
          fin_n   = 1'b1;
          pend_n  = 1'b0;
          state_n = SEND;
        end else begin
          wr_en   = 1'b1;
          wr_word = mark_q ? 32'h0 : 32'h8000_0000;
          mark_n  = 1'b1;
          idx_n   = idx_q + 6'd1;
          // length no longer fits: spill into another block
          if (idx_q == last_idx) begin
            fin_n   = 1'b0;
            pend_n  = 1'b1;
            state_n = SEND;
          end
        end
      end
      SEND: begin
        first_n = 1'b0;
        state_n = WAIT;
      end
      WAIT: begin
        if (blk_done) begin
          clr_blk = 1'b1;
          idx_n   = 6'd0;
          if (pend_q) begin
            pend_n  = 1'b0;
            state_n = PAD;
          end else if (!fin_q) begin
            state_n = FILL;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      cnt_q   <= '0;
      size_q  <= 2'b00;
      mark_q  <= 1'b0;
      fin_q   <= 1'b0;
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      size_q  <= size_n;
      mark_q  <= mark_n;
      fin_q   <= fin_n;
      pend_q  <= pend_n;
      first_q <= first_n;
      done_q  <= done_n;
      err_q   <= err_n;
      if (clr_blk) begin
        blk_q <= '0;
      end else begin
        for (int w = 0; w < 32; w++) begin
          if (wr_en && idx_q < n_words && slot == 6'(w))
            blk_q[1023-32*w -: 32] <= wr_word;
        end
        if (wr_len) begin
          if (wide) blk_q[127:0] <= len_field;
          else      blk_q[63:0]  <= len_field[63:0];
        end
      end
    end
  end

  assign blk       = blk_q;
  assign hash_size = size_q;
  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == SEND);
  assign blk_start = (state_q == SEND) && first_q;
  assign msg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// tb_sha_msg_padder: directed scenarios for the SHA-2 padder.
// Each task drives one scenario and checks against hand-computed blocks.
module tb_sha_msg_padder;

  logic          clk;
  logic          rst;
  logic          cfg_start;
  logic [1:0]    cfg_hash_size;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic [2:0]    in_bytes;
  logic [1023:0] blk;
  logic          blk_start;
  logic          blk_valid;
  logic          blk_done;
  logic [1:0]    hash_size;
  logic          msg_done;
  logic          cfg_err;

  int n_cmp;
  int n_bad;
  logic [31:0] ew [32];

  sha_msg_padder #(.CNT_W(61)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_hash_size (cfg_hash_size),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_bytes      (in_bytes),
    .blk           (blk),
    .blk_start     (blk_start),
    .blk_valid     (blk_valid),
    .blk_done      (blk_done),
    .hash_size     (hash_size),
    .msg_done      (msg_done),
    .cfg_err       (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ew;
    for (int i = 0; i < 32; i++) ew[i] = 32'h0;
  endtask

  function automatic logic [1023:0] build(input bit wide);
    logic [1023:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      if (wide) b[1023-32*i -: 32] = ew[i];
      else if (i < 16) b[511-32*i -: 32] = ew[i];
    end
    return b;
  endfunction

  function automatic int diff_slot(input logic [1023:0] a, input logic [1023:0] b);
    for (int s = 0; s < 32; s++)
      if (a[1023-32*s -: 32] !== b[1023-32*s -: 32]) return s;
    return -1;
  endfunction

  function automatic logic [31:0] slot_word(input logic [1023:0] a, input int s);
    if (s < 0) return 32'h0;
    return a[1023-32*s -: 32];
  endfunction

  task automatic start_msg(input logic [1:0] sz);
    cfg_start = 1'b1;
    cfg_hash_size = sz;
    tick;
    cfg_start = 1'b0;
    cfg_hash_size = 2'b00;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last,
                           input logic [2:0] nbytes, output bit to);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nbytes;
    k = 0;
    while (!in_ready && k < 100) begin
      tick;
      k++;
    end
    to = !in_ready;
    tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
    in_data  = 32'h0;
  endtask

  task automatic wait_valid(output bit to);
    int k;
    k = 0;
    while (!blk_valid && k < 100) begin
      tick;
      k++;
    end
    to = !blk_valid;
  endtask

  task automatic ack_block;
    tick;
    blk_done = 1'b1;
    tick;
    blk_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({blk_valid, blk_start, in_ready, msg_done, cfg_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 00000",
               {blk_valid, blk_start, in_ready, msg_done, cfg_err});
    end
    n_cmp++;
    if (blk !== '0 || hash_size !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_blk: got size %b blk_nonzero %0d want size 00 blk 0",
               hash_size, (blk != '0));
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_abc;
    bit to;
    logic [1023:0] e;
    int s;
    start_msg(2'b01);
    send_word(32'h6162_6300, 1'b1, 3'd3, to);
    wait_valid(to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL abc_valid: got blk_valid 0 want 1");
    end
    clear_ew;
    ew[0]  = 32'h6162_6380;
    ew[15] = 32'h0000_0018;
    e = build(1'b0);
    n_cmp++;
    if (blk !== e) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL abc_blk: slot %0d got %h want %h", s,
               slot_word(blk, s), slot_word(e, s));
    end
    n_cmp++;
    if (blk_start !== 1'b1) begin
      n_bad++;
      $display("FAIL abc_start: got %b want 1", blk_start);
    end
    ack_block;
    n_cmp++;
    if (msg_done !== 1'b1) begin
      n_bad++;
      $display("FAIL abc_msg_done: got %b want 1", msg_done);
    end
    tick;
    n_cmp++;
    if (msg_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abc_msg_done_pulse: got %b want 0", msg_done);
    end
  endtask

  task automatic test_56_bytes;
    bit to;
    bit to_any;
    logic [1023:0] e;
    int s;
    to_any = 1'b0;
    start_msg(2'b01);
    for (int i = 0; i < 14; i++) begin
      send_word(32'h1000_0000 + 32'(i), (i == 13), 3'd4, to);
      to_any |= to;
    end
    wait_valid(to);
    to_any |= to;
    n_cmp++;
    if (to_any) begin
      n_bad++;
      $display("FAIL b56_handshake: got timeout 1 want 0");
    end
    clear_ew;
    for (int i = 0; i < 14; i++) ew[i] = 32'h1000_0000 + 32'(i);
    ew[14] = 32'h8000_0000;
    e = build(1'b0);
    n_cmp++;
    if (blk !== e || blk_start !== 1'b1) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL b56_blk0: start %b slot %0d got %h want start 1 %h",
               blk_start, s, slot_word(blk, s), slot_word(e, s));
    end
    tick;
    n_cmp++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b56_wait: got ready %b valid %b want 0 0", in_ready, blk_valid);
    end
    blk_done = 1'b1;
    tick;
    blk_done = 1'b0;
    wait_valid(to);
    clear_ew;
    ew[15] = 32'h0000_01C0;
    e = build(1'b0);
    n_cmp++;
    if (to || blk !== e || blk_start !== 1'b0) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL b56_blk1: to %b start %b slot %0d got %h want to 0 start 0 %h",
               to, blk_start, s, slot_word(blk, s), slot_word(e, s));
    end
    ack_block;
    n_cmp++;
    if (msg_done !== 1'b1) begin
      n_bad++;
      $display("FAIL b56_msg_done: got %b want 1", msg_done);
    end
    tick;
  endtask

  task automatic test_384_empty;
    bit to;
    logic [1023:0] e;
    int s;
    start_msg(2'b10);
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0, to);
    wait_valid(to);
    clear_ew;
    ew[0] = 32'h8000_0000;
    e = build(1'b1);
    n_cmp++;
    if (to || blk !== e) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL e384_blk: to %b slot %0d got %h want %h",
               to, s, slot_word(blk, s), slot_word(e, s));
    end
    n_cmp++;
    if (hash_size !== 2'b10 || blk_start !== 1'b1) begin
      n_bad++;
      $display("FAIL e384_size: got size %b start %b want 10 1", hash_size, blk_start);
    end
    ack_block;
    n_cmp++;
    if (msg_done !== 1'b1) begin
      n_bad++;
      $display("FAIL e384_msg_done: got %b want 1", msg_done);
    end
    tick;
  endtask

  task automatic test_64_bytes;
    bit to;
    bit to_any;
    logic [1023:0] e;
    int s;
    to_any = 1'b0;
    start_msg(2'b01);
    for (int i = 0; i < 16; i++) begin
      send_word(32'hA5A5_0000 + 32'(i * 3), (i == 15), 3'd4, to);
      to_any |= to;
    end
    wait_valid(to);
    to_any |= to;
    clear_ew;
    for (int i = 0; i < 16; i++) ew[i] = 32'hA5A5_0000 + 32'(i * 3);
    e = build(1'b0);
    n_cmp++;
    if (to_any || blk !== e) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL b64_blk0: to %b slot %0d got %h want %h",
               to_any, s, slot_word(blk, s), slot_word(e, s));
    end
    tick;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL b64_wait_ready: cycle %0d got %b want 0", k, in_ready);
      end
      tick;
    end
    blk_done = 1'b1;
    tick;
    blk_done = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b64_pad_ready: got %b want 0", in_ready);
    end
    wait_valid(to);
    in_valid = 1'b0;
    in_data  = 32'h0;
    clear_ew;
    ew[0]  = 32'h8000_0000;
    ew[15] = 32'h0000_0200;
    e = build(1'b0);
    n_cmp++;
    if (to || blk !== e || blk_start !== 1'b0) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL b64_blk1: to %b start %b slot %0d got %h want %h",
               to, blk_start, s, slot_word(blk, s), slot_word(e, s));
    end
    ack_block;
    tick;
  endtask

  task automatic test_512_spill;
    bit to;
    bit to_any;
    logic [1023:0] e;
    int s;
    to_any = 1'b0;
    start_msg(2'b11);
    for (int i = 0; i < 29; i++) begin
      send_word(32'h0101_0101 * 32'(i + 1), 1'b0, 3'd0, to);
      to_any |= to;
    end
    send_word(32'hAABB_CC00, 1'b1, 3'd3, to);
    to_any |= to;
    wait_valid(to);
    to_any |= to;
    clear_ew;
    for (int i = 0; i < 29; i++) ew[i] = 32'h0101_0101 * 32'(i + 1);
    ew[29] = 32'hAABB_CC80;
    e = build(1'b1);
    n_cmp++;
    if (to_any || blk !== e || blk_start !== 1'b1) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL s512_blk0: to %b start %b slot %0d got %h want %h",
               to_any, blk_start, s, slot_word(blk, s), slot_word(e, s));
    end
    ack_block;
    wait_valid(to);
    clear_ew;
    ew[31] = 32'h0000_03B8;
    e = build(1'b1);
    n_cmp++;
    if (to || blk !== e || blk_start !== 1'b0) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL s512_blk1: to %b start %b slot %0d got %h want %h",
               to, blk_start, s, slot_word(blk, s), slot_word(e, s));
    end
    ack_block;
    n_cmp++;
    if (msg_done !== 1'b1 || hash_size !== 2'b11) begin
      n_bad++;
      $display("FAIL s512_done: got done %b size %b want 1 11", msg_done, hash_size);
    end
    tick;
  endtask

  task automatic test_cfg_err;
    int seen;
    cfg_start = 1'b1;
    cfg_hash_size = 2'b00;
    tick;
    cfg_start = 1'b0;
    seen = int'(cfg_err);
    tick;
    seen += int'(cfg_err);
    n_cmp++;
    if (seen != 1) begin
      n_bad++;
      $display("FAIL cfg_err_pulse: got %0d cycles want 1", seen);
    end
    n_cmp++;
    if (in_ready !== 1'b0 || hash_size !== 2'b11) begin
      n_bad++;
      $display("FAIL cfg_err_idle: got ready %b size %b want 0 11", in_ready, hash_size);
    end
  endtask

  task automatic test_mask_and_ignore;
    bit to;
    logic [1023:0] e;
    int s;
    start_msg(2'b01);
    cfg_start = 1'b1;
    cfg_hash_size = 2'b00;
    blk_done = 1'b1;
    tick;
    cfg_start = 1'b0;
    blk_done = 1'b0;
    tick;
    n_cmp++;
    if (in_ready !== 1'b1 || cfg_err !== 1'b0 || hash_size !== 2'b01) begin
      n_bad++;
      $display("FAIL ignore_in_fill: got ready %b err %b size %b want 1 0 01",
               in_ready, cfg_err, hash_size);
    end
    send_word(32'h1122_3344, 1'b1, 3'd2, to);
    wait_valid(to);
    clear_ew;
    ew[0]  = 32'h1122_8000;
    ew[15] = 32'h0000_0010;
    e = build(1'b0);
    n_cmp++;
    if (to || blk !== e) begin
      n_bad++;
      s = diff_slot(blk, e);
      $display("FAIL mask2_blk: to %b slot %0d got %h want %h",
               to, s, slot_word(blk, s), slot_word(e, s));
    end
    ack_block;
    tick;
  endtask

  task automatic test_reset_in_wait;
    bit to;
    int hits;
    start_msg(2'b01);
    send_word(32'h6162_6300, 1'b1, 3'd3, to);
    wait_valid(to);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if (blk !== '0 || hash_size !== 2'b00 ||
        {in_ready, blk_valid, blk_start, msg_done, cfg_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_wait: got size %b strobes %b blk_nonzero %0d want 00 00000 0",
               hash_size, {in_ready, blk_valid, blk_start, msg_done, cfg_err},
               (blk != '0));
    end
    blk_done = 1'b1;
    tick;
    blk_done = 1'b0;
    hits = int'(msg_done) + int'(blk_valid) + int'(in_ready);
    tick;
    hits += int'(msg_done) + int'(blk_valid) + int'(in_ready);
    n_cmp++;
    if (hits != 0) begin
      n_bad++;
      $display("FAIL rst_stale_done: got %0d active strobes want 0", hits);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    cfg_start = 1'b0;
    cfg_hash_size = 2'b00;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_last = 1'b0;
    in_bytes = 3'd0;
    blk_done = 1'b0;
    clear_ew;
    test_reset;
    test_abc;
    test_56_bytes;
    test_384_empty;
    test_64_bytes;
    test_512_spill;
    test_cfg_err;
    test_mask_and_ignore;
    test_reset_in_wait;
    test_abc;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
